led_fade_drv: RTL and testbench
===============================

LED_FADE_DRV -- requirements
Module: led_fade_drv

Interface
REQ-001 Parameter PWM_DIV, default 2, clk cycles per PWM slot (legal range 1..65535).
REQ-002 Parameter DECAY_DIV, default 4, PWM periods per brightness decay step (legal range 1..255).
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-high reset.
REQ-005 Port pattern_in, input, 12, LED on/off pattern from the upstream rotating-pattern generator, same clock domain.
REQ-006 Port enable, input, 1, 1 = drive LEDs, 0 = blank and clear.
REQ-007 Port led, output, 12, registered PWM drive per LED, 1 = lit.
REQ-008 Port frame_sync, output, 1, registered one-cycle pulse marking the end of each PWM period.

Function
REQ-009 The block SHALL register pattern_in into pattern_q every cycle.
REQ-010 The block SHALL keep a prescaler presc counting 0..PWM_DIV-1 and wrapping to 0; slot_tick = (presc == PWM_DIV-1).
REQ-011 The block SHALL keep a 4-bit pwm_cnt that advances on slot_tick, counting 0..14 and wrapping 14 -> 0 (15 slots per period).
REQ-012 period_end SHALL be slot_tick AND pwm_cnt == 14; frame_sync SHALL equal period_end delayed by one cycle.
REQ-013 The block SHALL keep a decay counter advancing on period_end, counting 0..DECAY_DIV-1 and wrapping; decay_tick = period_end AND decay counter == DECAY_DIV-1.
REQ-014 Each LED i SHALL have a 4-bit level[i], updated every cycle with priority: pattern_q[i]=1 -> 15; else decay_tick AND level[i]>0 -> level[i]-1; else hold.
REQ-015 level[i] SHALL saturate at 0 and never wrap to 15.
REQ-016 A pattern_q[i]=1 coinciding with decay_tick SHALL load 15; the load takes priority over the decrement.
REQ-017 led[i] SHALL be registered as enable AND (level[i] > pwm_cnt): level 15 gives constant on, level 0 gives constant off, level L gives duty L/15.
REQ-018 Latency: pattern_in[i] sampled high at edge N SHALL give led[i]=1 after edge N+2 whenever enable=1.
REQ-019 While enable=0, presc, pwm_cnt, the decay counter and all level[i] SHALL be cleared to 0, and led and frame_sync SHALL be 0 from the next edge on.
REQ-020 On enable 0->1, counting SHALL restart from presc=0, pwm_cnt=0.
REQ-021 All 12 channels SHALL share the single prescaler, pwm_cnt and decay counter; there is no per-channel phase offset.

Reset
REQ-022 rst=1 SHALL immediately, without a clock, set pattern_q, presc, pwm_cnt, the decay counter, all level[i], led and frame_sync to 0.
REQ-023 Assertion of rst mid-fade SHALL abandon the fade; after release, operation SHALL restart as from power-up, with the first slot_tick PWM_DIV cycles after the first post-release edge.
REQ-024 The block SHALL clear no state on release of rst.

Verification (PWM_DIV=2, DECAY_DIV=1, enable=1 unless stated)
REQ-025 Assert rst asynchronously between clock edges -> led=12'h000 and frame_sync=0 before the next edge.
REQ-026 Hold pattern_in=12'h001 -> led[0]=1 from the third edge on, constant; led[11:1]=0; frame_sync pulses once every 30 cycles.
REQ-027 Apply pattern_in=12'h001 for 5 cycles, then 12'h000 -> level[0] falls 15->14->...->0, one step per 30 cycles; per period led[0] high-count is 14,13,...,1,0; stays 0 after 450 cycles.
REQ-028 During the fade, reassert pattern_in[0] on the exact decay_tick cycle -> level[0]=15, not 14, and led[0] returns to constant on.
REQ-029 Drop enable to 0 mid-fade for 3 cycles -> led=0 from the next edge and all levels 0; on re-enable with pattern_in=0, led stays 0; on re-enable with pattern_in=12'hFFF, all LEDs are lit after 2 edges.
REQ-030 Drive the upstream rotating pattern, stepping every 60 cycles -> each newly lit LED is constant on, and each vacated LED shows a decaying trail with no glitch at the pwm_cnt 14->0 wrap.

Source files
------------

// File: rtl/led_fade_drv.sv
// ---------------------------------------------------------------------------
// led_fade_drv
//
// Twelve-channel LED driver that turns an on/off pattern into PWM drive with
// a fading afterglow. Every LED that is switched on by the pattern snaps to
// full brightness (level 15). Once the pattern lets go of it, the LED decays
// one level every DECAY_DIV PWM periods until it is dark. Brightness is
// rendered as a 15-slot PWM, so level L is lit for L of the 15 slots. All
// channels share one prescaler, one slot counter and one decay counter, so
// every LED is in phase with every other.
//
// Parameters
//   PWM_DIV    clk cycles per PWM slot (1..65535)
//   DECAY_DIV  PWM periods per brightness decay step (1..255)
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   pattern_in  [11:0] on/off pattern from the rotating-pattern generator
//   enable      1 = drive LEDs, 0 = blank LEDs and clear all fade state
//   led         [11:0] registered PWM drive, 1 = lit
//   frame_sync  registered one-cycle pulse after the last slot of a period
// ---------------------------------------------------------------------------
module led_fade_drv #(
  parameter int unsigned PWM_DIV   = 2,
  parameter int unsigned DECAY_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pattern_in,
  input  logic        enable,
  output logic [11:0] led,
  output logic        frame_sync
);

  localparam logic [15:0] PRESC_LAST = 16'(PWM_DIV - 1);
  localparam logic [7:0]  DECAY_LAST = 8'(DECAY_DIV - 1);
  localparam logic [3:0]  SLOT_LAST  = 4'd14;
  localparam logic [3:0]  LEVEL_FULL = 4'd15;

  logic [11:0]      pattern_q;
  logic [15:0]      presc_q,      presc_d;
  logic [3:0]       pwm_cnt_q,    pwm_cnt_d;
  logic [7:0]       decay_cnt_q,  decay_cnt_d;
  logic [11:0][3:0] level_q,      level_d;
  logic [11:0]      led_q,        led_d;
  logic             frame_sync_q, frame_sync_d;

  logic slot_tick;
  logic period_end;
  logic decay_tick;

  assign led        = led_q;
  assign frame_sync = frame_sync_q;

  // Timing strobes decoded from the shared counters. period_end marks the
  // final clock of slot 14; decay_tick is the subset of those period ends on
  // which the brightness levels step down.
  always_comb begin
    slot_tick  = (presc_q == PRESC_LAST);
    period_end = slot_tick && (pwm_cnt_q == SLOT_LAST);
    decay_tick = period_end && (decay_cnt_q == DECAY_LAST);
  end

  // Shared timebase: prescaler -> PWM slot counter -> decay counter. Holding
  // enable low parks everything at zero, so re-enabling always starts a
  // fresh period from slot 0.
  always_comb begin
    presc_d     = presc_q;
    pwm_cnt_d   = pwm_cnt_q;
    decay_cnt_d = decay_cnt_q;

    if (!enable) begin
      presc_d     = '0;
      pwm_cnt_d   = '0;
      decay_cnt_d = '0;
    end else begin
      presc_d = slot_tick ? 16'd0 : presc_q + 16'd1;

      if (slot_tick) begin
        pwm_cnt_d = (pwm_cnt_q == SLOT_LAST) ? 4'd0 : pwm_cnt_q + 4'd1;
      end

      if (period_end) begin
        decay_cnt_d = (decay_cnt_q == DECAY_LAST) ? 8'd0 : decay_cnt_q + 8'd1;
      end
    end
  end

  // Per-channel brightness. A lit pattern bit wins over a coincident decay
  // step, so a channel re-triggered on the decay cycle lands on 15 rather
  // than 14. The decrement is guarded so a dark channel stays dark instead
  // of wrapping back to full brightness.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 12; i++) begin
      if (!enable) begin
        level_d[i] = 4'd0;
      end else if (pattern_q[i]) begin
        level_d[i] = LEVEL_FULL;
      end else if (decay_tick && (level_q[i] != 4'd0)) begin
        level_d[i] = level_q[i] - 4'd1;
      end
    end
  end

  // PWM compare. Level 15 exceeds every slot index (max 14) so it is solid
  // on; level 0 never exceeds one so it is solid off.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 12; i++) begin
      led_d[i] = enable && (level_q[i] > pwm_cnt_q);
    end
    frame_sync_d = enable && period_end;
  end

  // State registers. Reset clears everything immediately; nothing is
  // cleared on release, so the first edge afterwards simply starts counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q    <= '0;
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      decay_cnt_q  <= '0;
      level_q      <= '0;
      led_q        <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      pattern_q    <= pattern_in;
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      decay_cnt_q  <= decay_cnt_d;
      level_q      <= level_d;
      led_q        <= led_d;
      frame_sync_q <= frame_sync_d;
    end
  end

endmodule

// File: tb/tb_led_fade_drv.sv
// ---------------------------------------------------------------------------
// tb_led_fade_drv
//
// Directed bench for led_fade_drv with PWM_DIV=2, DECAY_DIV=1. One PWM
// period is therefore 30 clocks and every period end is also a decay step.
// Edge numbering: after do_reset returns, the next rising edge is edge 1.
// With that numbering frame_sync is high after edges 30, 60, ..., decay
// steps land on those same edges, and led after edge n reflects the level
// and slot held after edge n-1 (slot = ((n-1) mod 30) / 2).
// ---------------------------------------------------------------------------
module tb_led_fade_drv;

  logic        clk;
  logic        rst;
  logic [11:0] pattern_in;
  logic        enable;
  logic [11:0] led;
  logic        frame_sync;

  int checks = 0;
  int errors = 0;

  led_fade_drv #(
    .PWM_DIV   (2),
    .DECAY_DIV (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pattern_in (pattern_in),
    .enable     (enable),
    .led        (led),
    .frame_sync (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges, release just after an edge.
  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b1;
    pattern_in = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Light LED0 for 5 edges, then release it; returns after edge 30.
  task automatic start_fade();
    pattern_in = 12'h001;
    repeat (5) step();
    pattern_in = 12'h000;
    repeat (25) step();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    enable     = 1'b1;
    pattern_in = 12'hFFF;
    #2;
    checks++;
    if (led !== 12'h000 || frame_sync !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial led=%h fs=%b expected led=000 fs=0", led, frame_sync);
    end
    repeat (3) step();
    checks++;
    if (led !== 12'h000 || frame_sync !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held led=%h fs=%b expected led=000 fs=0", led, frame_sync);
    end
  endtask

  task automatic test_hold();
    int fsCount;
    logic [11:0] expLed;
    do_reset();
    pattern_in = 12'h001;
    fsCount = 0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (frame_sync === 1'b1) fsCount++;
      expLed = (n >= 3) ? 12'h001 : 12'h000;
      checks++;
      if (led !== expLed) begin
        errors++;
        $display("[TB] FAIL hold_led edge=%0d led=%h expected %h", n, led, expLed);
      end
      if (n == 30 || n == 60) begin
        checks++;
        if (frame_sync !== 1'b1) begin
          errors++;
          $display("[TB] FAIL hold_frame_sync edge=%0d fs=%b expected 1", n, frame_sync);
        end
      end
    end
    checks++;
    if (fsCount != 2) begin
      errors++;
      $display("[TB] FAIL hold_frame_count got %0d expected 2", fsCount);
    end
  endtask

  task automatic test_fade();
    int hi;
    int stray;
    int expHi;
    do_reset();
    start_fade();
    for (int m = 1; m <= 16; m++) begin
      hi    = 0;
      stray = 0;
      for (int j = 1; j <= 30; j++) begin
        step();
        if (led[0] === 1'b1) hi++;
        if (led[11:1] !== 11'd0) stray++;
        if (j == 30) begin
          checks++;
          if (frame_sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fade_frame_sync period=%0d fs=%b expected 1", m, frame_sync);
          end
        end
      end
      expHi = (m <= 15) ? 2 * (15 - m) : 0;
      checks++;
      if (hi != expHi) begin
        errors++;
        $display("[TB] FAIL fade_duty period=%0d high_cycles=%0d expected %0d", m, hi, expHi);
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("[TB] FAIL fade_other_leds period=%0d lit_cycles=%0d expected 0", m, stray);
      end
    end
  endtask

  task automatic test_reload();
    int hi;
    do_reset();
    start_fade();
    // Edges 31..60: level 14, with pattern re-asserted so it is registered
    // during the decay cycle (sampled at edge 59).
    hi = 0;
    for (int n = 31; n <= 60; n++) begin
      if (n == 59) pattern_in = 12'h001;
      if (n == 60) pattern_in = 12'h000;
      step();
      if (led[0] === 1'b1) hi++;
    end
    checks++;
    if (hi != 28) begin
      errors++;
      $display("[TB] FAIL reload_before high_cycles=%0d expected 28", hi);
    end
    hi = 0;
    for (int n = 61; n <= 90; n++) begin
      step();
      if (led[0] === 1'b1) hi++;
    end
    checks++;
    if (hi != 30) begin
      errors++;
      $display("[TB] FAIL reload_full high_cycles=%0d expected 30", hi);
    end
    hi = 0;
    for (int n = 91; n <= 120; n++) begin
      step();
      if (led[0] === 1'b1) hi++;
    end
    checks++;
    if (hi != 28) begin
      errors++;
      $display("[TB] FAIL reload_after high_cycles=%0d expected 28", hi);
    end
  endtask

  task automatic test_enable();
    int stray;
    do_reset();
    start_fade();
    repeat (10) step();
    checks++;
    if (led !== 12'h001) begin
      errors++;
      $display("[TB] FAIL enable_midfade led=%h expected 001", led);
    end
    enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (led !== 12'h000 || frame_sync !== 1'b0) begin
        errors++;
        $display("[TB] FAIL enable_blank cycle=%0d led=%h fs=%b expected 000 0", k, led, frame_sync);
      end
    end
    enable = 1'b1;
    stray  = 0;
    for (int r = 1; r <= 60; r++) begin
      step();
      if (led !== 12'h000) stray++;
      if (r == 29 || r == 30 || r == 60) begin
        checks++;
        if (frame_sync !== (r != 29)) begin
          errors++;
          $display("[TB] FAIL enable_restart_sync edge=%0d fs=%b expected %b", r, frame_sync, (r != 29));
        end
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL enable_levels_cleared lit_cycles=%0d expected 0", stray);
    end
    pattern_in = 12'hFFF;
    enable     = 1'b0;
    repeat (3) step();
    checks++;
    if (led !== 12'h000) begin
      errors++;
      $display("[TB] FAIL enable_off_with_pattern led=%h expected 000", led);
    end
    enable = 1'b1;
    step();
    checks++;
    if (led !== 12'h000) begin
      errors++;
      $display("[TB] FAIL enable_first_edge led=%h expected 000", led);
    end
    stray = 0;
    for (int r = 2; r <= 31; r++) begin
      step();
      if (led !== 12'hFFF) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL enable_all_lit unlit_cycles=%0d expected 0", stray);
    end
    pattern_in = 12'h000;
  endtask

  task automatic test_async_reset();
    int stray;
    do_reset();
    start_fade();
    checks++;
    if (led !== 12'h001 || frame_sync !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre led=%h fs=%b expected 001 1", led, frame_sync);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 12'h000 || frame_sync !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset led=%h fs=%b expected 000 0", led, frame_sync);
    end
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stray = 0;
    for (int r = 1; r <= 30; r++) begin
      step();
      if (led !== 12'h000) stray++;
      if (r == 29 || r == 30) begin
        checks++;
        if (frame_sync !== (r == 30)) begin
          errors++;
          $display("[TB] FAIL async_restart_sync edge=%0d fs=%b expected %b", r, frame_sync, (r == 30));
        end
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL async_fade_abandoned lit_cycles=%0d expected 0", stray);
    end
  endtask

  task automatic test_rotate();
    logic [11:0] expLed;
    int m;
    int lvl;
    int slot;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      pattern_in = 12'h000;
      pattern_in[(n - 1) / 60] = 1'b1;
      step();
      expLed = 12'h000;
      for (int s = 0; s <= 4; s++) begin
        if (n < 60 * s + 3) begin
          expLed[s] = 1'b0;
        end else if (n <= 60 * s + 90) begin
          expLed[s] = 1'b1;
        end else begin
          m    = (n - 1) / 30;
          lvl  = 2 * s + 17 - m;
          if (lvl < 0) lvl = 0;
          slot = (n - 1 - 30 * m) / 2;
          expLed[s] = (lvl > slot);
        end
      end
      checks++;
      if (led !== expLed) begin
        errors++;
        $display("[TB] FAIL rotate_led edge=%0d led=%h expected %h", n, led, expLed);
      end
    end
    pattern_in = 12'h000;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    pattern_in = 12'h000;
    test_reset();
    test_hold();
    test_fade();
    test_reload();
    test_enable();
    test_async_reset();
    test_rotate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
